// File: rtl/fp_issue_sequencer.sv
// Issue/writeback sequencer around the FP execution unit: registers one op,
// resolves rounding mode, holds the unit enable until done, and guards it with a watchdog.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both 1;
// in_valid/out_valid must hold with stable payload until that edge, and ready may toggle freely.
module fp_issue_sequencer #(
  parameter int FP_WIDTH   = 32,
  parameter int UNIT_WIDTH = 3,
  parameter int CMD_WIDTH  = 8,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [UNIT_WIDTH-1:0] in_unit,
  input  logic [CMD_WIDTH-1:0]  in_command,
  input  logic [2:0]            in_rounding_mode,
  input  logic [31:0]           in_int_src1,
  input  logic [FP_WIDTH-1:0]   in_fp_src1,
  input  logic [FP_WIDTH-1:0]   in_fp_src2,
  input  logic [FP_WIDTH-1:0]   in_fp_src3,
  input  logic [4:0]            in_rd,
  input  logic                  in_rd_is_fp,
  input  logic [2:0]            frm,
  input  logic                  flush,
  input  logic                  fflags_clear,
  output logic [4:0]            fflags_acc,
  output logic                  fpu_enable,
  output logic                  fpu_flush,
  output logic [UNIT_WIDTH-1:0] fpu_unit,
  output logic [CMD_WIDTH-1:0]  fpu_command,
  output logic [2:0]            fpu_rounding_mode,
  output logic [31:0]           fpu_int_src1,
  output logic [FP_WIDTH-1:0]   fpu_fp_src1,
  output logic [FP_WIDTH-1:0]   fpu_fp_src2,
  output logic [FP_WIDTH-1:0]   fpu_fp_src3,
  input  logic [31:0]           fpu_int_result,
  input  logic [FP_WIDTH-1:0]   fpu_fp_result,
  input  logic                  fpu_write_flags,
  input  logic [4:0]            fpu_flags,
  input  logic                  fpu_done,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4:0]            out_rd,
  output logic                  out_rd_is_fp,
  output logic [31:0]           out_int_result,
  output logic [FP_WIDTH-1:0]   out_fp_result,
  output logic                  out_illegal,
  output logic                  out_timeout,
  output logic [1:0]            dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [UNIT_WIDTH-1:0] unit_q, unit_d;
  logic [CMD_WIDTH-1:0]  cmd_q, cmd_d;
  logic [2:0]            rm_q, rm_d;
  logic [31:0]           int_src1_q, int_src1_d;
  logic [FP_WIDTH-1:0]   fp_src1_q, fp_src1_d;
  logic [FP_WIDTH-1:0]   fp_src2_q, fp_src2_d;
  logic [FP_WIDTH-1:0]   fp_src3_q, fp_src3_d;
  logic [4:0]            rd_q, rd_d;
  logic                  rd_is_fp_q, rd_is_fp_d;
  logic [31:0]           int_res_q, int_res_d;
  logic [FP_WIDTH-1:0]   fp_res_q, fp_res_d;
  logic                  illegal_q, illegal_d;
  logic                  timeout_q, timeout_d;
  logic [4:0]            fflags_q, fflags_d;

  logic [2:0] rm_resolved;
  logic       rm_bad;
  logic       accept;
  logic       wd_last;

  always_comb begin
    rm_resolved = (in_rounding_mode == 3'b111) ? frm : in_rounding_mode;
    rm_bad      = (rm_resolved >= 3'b101);
    in_ready    = rst && (state_q == ST_IDLE) && !flush;
    accept      = in_valid && in_ready;
    wd_last     = (cnt_q == CNT_W'(TIMEOUT - 1));
    fpu_enable  = (state_q == ST_EXEC);
    fpu_flush   = (state_q == ST_EXEC) && (flush || (wd_last && !fpu_done));
    out_valid   = (state_q == ST_HOLD);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    unit_d     = unit_q;
    cmd_d      = cmd_q;
    rm_d       = rm_q;
    int_src1_d = int_src1_q;
    fp_src1_d  = fp_src1_q;
    fp_src2_d  = fp_src2_q;
    fp_src3_d  = fp_src3_q;
    rd_d       = rd_q;
    rd_is_fp_d = rd_is_fp_q;
    int_res_d  = int_res_q;
    fp_res_d   = fp_res_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    fflags_d   = fflags_clear ? 5'd0 : fflags_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unit_d     = in_unit;
          cmd_d      = in_command;
          rm_d       = rm_resolved;
          int_src1_d = in_int_src1;
          fp_src1_d  = in_fp_src1;
          fp_src2_d  = in_fp_src2;
          fp_src3_d  = in_fp_src3;
          rd_d       = in_rd;
          rd_is_fp_d = in_rd_is_fp;
          cnt_d      = '0;
          if (rm_bad) begin
            // Reserved rounding mode: report without ever enabling the unit.
            state_d   = ST_HOLD;
            illegal_d = 1'b1;
            int_res_d = '0;
            fp_res_d  = '0;
          end else begin
            state_d = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        cnt_d = cnt_q + 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (fpu_done) begin
          state_d   = ST_HOLD;
          int_res_d = fpu_int_result;
          fp_res_d  = fpu_fp_result;
          if (fpu_write_flags) fflags_d = fflags_d | fpu_flags;
        end else if (wd_last) begin
          state_d   = ST_HOLD;
          timeout_d = 1'b1;
          int_res_d = '0;
          fp_res_d  = '0;
        end
      end
      ST_HOLD: begin
        if (flush || out_ready) begin
          state_d   = ST_IDLE;
          illegal_d = 1'b0;
          timeout_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      unit_q     <= '0;
      cmd_q      <= '0;
      rm_q       <= '0;
      int_src1_q <= '0;
      fp_src1_q  <= '0;
      fp_src2_q  <= '0;
      fp_src3_q  <= '0;
      rd_q       <= '0;
      rd_is_fp_q <= 1'b0;
      int_res_q  <= '0;
      fp_res_q   <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      fflags_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      unit_q     <= unit_d;
      cmd_q      <= cmd_d;
      rm_q       <= rm_d;
      int_src1_q <= int_src1_d;
      fp_src1_q  <= fp_src1_d;
      fp_src2_q  <= fp_src2_d;
      fp_src3_q  <= fp_src3_d;
      rd_q       <= rd_d;
      rd_is_fp_q <= rd_is_fp_d;
      int_res_q  <= int_res_d;
      fp_res_q   <= fp_res_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      fflags_q   <= fflags_d;
    end
  end

  assign fpu_unit          = unit_q;
  assign fpu_command       = cmd_q;
  assign fpu_rounding_mode = rm_q;
  assign fpu_int_src1      = int_src1_q;
  assign fpu_fp_src1       = fp_src1_q;
  assign fpu_fp_src2       = fp_src2_q;
  assign fpu_fp_src3       = fp_src3_q;
  assign out_rd            = rd_q;
  assign out_rd_is_fp      = rd_is_fp_q;
  assign out_int_result    = int_res_q;
  assign out_fp_result     = fp_res_q;
  assign out_illegal       = illegal_q;
  assign out_timeout       = timeout_q;
  assign fflags_acc        = fflags_q;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_fp_issue_sequencer.sv
// Bench for fp_issue_sequencer: the bench plays the FP unit, predicts each op's outcome
// from the issue rules, and a monitor checks every presented output against a queue.
module tb_fp_issue_sequencer;

  localparam int TB_TIMEOUT = 16;
  localparam int EW = 72;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_unit;
  logic [7:0]  in_command;
  logic [2:0]  in_rounding_mode;
  logic [31:0] in_int_src1;
  logic [31:0] in_fp_src1, in_fp_src2, in_fp_src3;
  logic [4:0]  in_rd;
  logic        in_rd_is_fp;
  logic [2:0]  frm;
  logic        flush;
  logic        fflags_clear;
  logic [4:0]  fflags_acc;
  logic        fpu_enable, fpu_flush;
  logic [2:0]  fpu_unit;
  logic [7:0]  fpu_command;
  logic [2:0]  fpu_rounding_mode;
  logic [31:0] fpu_int_src1;
  logic [31:0] fpu_fp_src1, fpu_fp_src2, fpu_fp_src3;
  logic [31:0] fpu_int_result, fpu_fp_result;
  logic        fpu_write_flags;
  logic [4:0]  fpu_flags;
  logic        fpu_done;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd;
  logic        out_rd_is_fp;
  logic [31:0] out_int_result, out_fp_result;
  logic        out_illegal, out_timeout;
  logic [1:0]  dbg_state;

  fp_issue_sequencer #(
    .FP_WIDTH(32), .UNIT_WIDTH(3), .CMD_WIDTH(8), .TIMEOUT(TB_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_unit(in_unit), .in_command(in_command),
    .in_rounding_mode(in_rounding_mode), .in_int_src1(in_int_src1),
    .in_fp_src1(in_fp_src1), .in_fp_src2(in_fp_src2), .in_fp_src3(in_fp_src3),
    .in_rd(in_rd), .in_rd_is_fp(in_rd_is_fp), .frm(frm), .flush(flush),
    .fflags_clear(fflags_clear), .fflags_acc(fflags_acc),
    .fpu_enable(fpu_enable), .fpu_flush(fpu_flush), .fpu_unit(fpu_unit),
    .fpu_command(fpu_command), .fpu_rounding_mode(fpu_rounding_mode),
    .fpu_int_src1(fpu_int_src1), .fpu_fp_src1(fpu_fp_src1), .fpu_fp_src2(fpu_fp_src2),
    .fpu_fp_src3(fpu_fp_src3), .fpu_int_result(fpu_int_result),
    .fpu_fp_result(fpu_fp_result), .fpu_write_flags(fpu_write_flags),
    .fpu_flags(fpu_flags), .fpu_done(fpu_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_rd_is_fp(out_rd_is_fp), .out_int_result(out_int_result),
    .out_fp_result(out_fp_result), .out_illegal(out_illegal), .out_timeout(out_timeout),
    .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  logic [EW-1:0] exp_q[$];
  logic [4:0] fflags_model;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every cycle an output is presented; retire on handshake or flush.
  always @(negedge clk) begin
    #2;
    if (rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_unexpected", 80'(out_valid), 80'(0));
      end else if (flush) begin
        void'(exp_q.pop_front());
      end else begin
        check("out_fields",
              80'({out_rd, out_rd_is_fp, out_int_result, out_fp_result, out_illegal, out_timeout}),
              80'(exp_q[0]));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic run_op(input logic [2:0] rm, input logic [2:0] frm_v, input int done_lat,
                        input logic wflags, input logic [4:0] flags, input logic [31:0] fres,
                        input int flush_at, input int hold_wait, input logic hold_flush,
                        input logic clr, input int rst_at);
    logic [2:0]  unit_v, rrm;
    logic [7:0]  cmd_v;
    logic [31:0] i1, f1, f2, f3, ires;
    logic [4:0]  rd_v;
    logic        rdfp_v, ill, ended;
    unit_v = 3'($urandom);
    cmd_v  = 8'($urandom);
    i1 = $urandom; f1 = $urandom; f2 = $urandom; f3 = $urandom; ires = $urandom;
    rd_v = 5'($urandom);
    rdfp_v = 1'($urandom);
    check("in_ready_idle", 80'(in_ready), 80'(1));
    in_valid = 1'b1; in_unit = unit_v; in_command = cmd_v; in_rounding_mode = rm;
    in_int_src1 = i1; in_fp_src1 = f1; in_fp_src2 = f2; in_fp_src3 = f3;
    in_rd = rd_v; in_rd_is_fp = rdfp_v; frm = frm_v;
    rrm = (rm == 3'b111) ? frm_v : rm;
    ill = (rrm >= 3'b101);
    if (ill) exp_q.push_back({rd_v, rdfp_v, 32'h0, 32'h0, 1'b1, 1'b0});
    @(negedge clk);
    in_valid = 1'b0;
    in_unit = 3'($urandom); in_command = 8'($urandom); in_rounding_mode = 3'($urandom);
    in_int_src1 = $urandom; in_fp_src1 = $urandom; in_fp_src2 = $urandom;
    in_fp_src3 = $urandom; in_rd = 5'($urandom); frm = 3'($urandom);
    ended = 1'b0;
    if (!ill) begin
      for (int k = 0; k < TB_TIMEOUT && !ended; k++) begin
        check("fpu_enable_exec", 80'(fpu_enable), 80'(1));
        check("in_ready_exec", 80'(in_ready), 80'(0));
        check("fpu_ctrl", 80'({fpu_unit, fpu_command, fpu_rounding_mode}), 80'({unit_v, cmd_v, rrm}));
        check("fpu_src", 80'({fpu_int_src1, fpu_fp_src1}), 80'({i1, f1}));
        check("fpu_src23", 80'({fpu_fp_src2, fpu_fp_src3}), 80'({f2, f3}));
        if (k == rst_at) begin
          rst = 1'b0;
          @(negedge clk);
          fflags_model = 5'd0;
          check("rst_ctrl", 80'({fpu_enable, out_valid, fflags_acc, out_illegal, out_timeout, in_ready}), 80'(0));
          check("rst_operands", 80'({fpu_fp_src1, fpu_int_src1, fpu_rounding_mode}), 80'(0));
          check("rst_results", 80'({out_fp_result, out_int_result, out_rd}), 80'(0));
          rst = 1'b1;
          #1;
          check("in_ready_after_rst", 80'(in_ready), 80'(1));
          return;
        end
        if (k == flush_at) begin
          flush = 1'b1; fpu_done = 1'b1; fpu_write_flags = 1'b1; fpu_flags = flags;
          fpu_fp_result = fres; fpu_int_result = ires;
          #1;
          check("fpu_flush_on_flush", 80'(fpu_flush), 80'(1));
          @(negedge clk);
          flush = 1'b0; fpu_done = 1'b0; fpu_write_flags = 1'b0;
          #1;
          check("flush_no_valid", 80'(out_valid), 80'(0));
          check("flush_ready", 80'(in_ready), 80'(1));
          check("flush_fflags", 80'(fflags_acc), 80'(fflags_model));
          return;
        end
        if (k == done_lat) begin
          fpu_done = 1'b1; fpu_write_flags = wflags; fpu_flags = flags;
          fpu_fp_result = fres; fpu_int_result = ires; fflags_clear = clr;
          if (clr) fflags_model = 5'd0;
          if (wflags) fflags_model = fflags_model | flags;
          exp_q.push_back({rd_v, rdfp_v, ires, fres, 1'b0, 1'b0});
          #1;
          check("fpu_flush_done", 80'(fpu_flush), 80'(0));
          ended = 1'b1;
        end else begin
          #1;
          check("fpu_flush_wd", 80'(fpu_flush), 80'(k == TB_TIMEOUT - 1));
          if (k == TB_TIMEOUT - 1) exp_q.push_back({rd_v, rdfp_v, 32'h0, 32'h0, 1'b0, 1'b1});
        end
        @(negedge clk);
        fpu_done = 1'b0; fpu_write_flags = 1'b0; fflags_clear = 1'b0;
        fpu_flags = 5'($urandom); fpu_fp_result = $urandom; fpu_int_result = $urandom;
      end
    end
    check("hold_valid", 80'(out_valid), 80'(1));
    check("hold_enable_off", 80'({fpu_enable, fpu_flush, in_ready}), 80'(0));
    check("hold_fflags", 80'(fflags_acc), 80'(fflags_model));
    for (int h = 0; h < hold_wait; h++) begin
      @(negedge clk);
      check("hold_wait_state", 80'({out_valid, in_ready, fpu_enable}), 80'(3'b100));
    end
    if (hold_flush) begin
      flush = 1'b1;
      out_ready = 1'($urandom);
    end else begin
      out_ready = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b0;
    #1;
    check("post_hold_valid", 80'(out_valid), 80'(0));
    check("post_hold_ready", 80'(in_ready), 80'(1));
    check("post_hold_status", 80'({out_illegal, out_timeout}), 80'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL tb_time_limit actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int dl, fa;
    rst = 1'b0; in_valid = 1'b0; in_unit = '0; in_command = '0; in_rounding_mode = '0;
    in_int_src1 = '0; in_fp_src1 = '0; in_fp_src2 = '0; in_fp_src3 = '0; in_rd = '0;
    in_rd_is_fp = 1'b0; frm = '0; flush = 1'b0; fflags_clear = 1'b0;
    fpu_int_result = '0; fpu_fp_result = '0; fpu_write_flags = 1'b0; fpu_flags = '0;
    fpu_done = 1'b0; out_ready = 1'b0; fflags_model = 5'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 80'({in_ready, out_valid, fpu_enable, fpu_flush, out_illegal, out_timeout}), 80'(0));
    check("reset_fflags", 80'(fflags_acc), 80'(0));
    check("reset_operands", 80'({fpu_fp_src1, fpu_int_src1, fpu_rounding_mode, fpu_unit}), 80'(0));
    check("reset_results", 80'({out_fp_result, out_int_result, out_rd, out_rd_is_fp}), 80'(0));
    rst = 1'b1;
    flush = 1'b1;
    #1;
    check("idle_flush_blocks_ready", 80'(in_ready), 80'(0));
    flush = 1'b0;
    #1;

    // MulAdd: single-cycle completion
    run_op(3'b000, 3'b000, 0, 1'b1, 5'h01, 32'h40400000, -1, 0, 1'b0, 1'b0, -1);
    // Sqrt: done on the 10th EXEC cycle, consumer stalls 3 cycles
    run_op(3'b001, 3'b000, 9, 1'b1, 5'h04, $urandom, -1, 3, 1'b0, 1'b0, -1);
    // Dynamic rounding mode resolves to frm
    run_op(3'b111, 3'b001, 2, 1'b0, 5'h1f, $urandom, -1, 0, 1'b0, 1'b0, -1);
    // Reserved rounding modes, direct and via frm
    run_op(3'b101, 3'b010, 0, 1'b1, 5'h1f, $urandom, -1, 1, 1'b0, 1'b0, -1);
    run_op(3'b110, 3'b000, 0, 1'b1, 5'h1f, $urandom, -1, 0, 1'b0, 1'b0, -1);
    run_op(3'b111, 3'b111, 0, 1'b1, 5'h1f, $urandom, -1, 0, 1'b0, 1'b0, -1);
    // Flush on 4th EXEC cycle with a coincident done carrying flags
    run_op(3'b001, 3'b000, 6, 1'b1, 5'h10, $urandom, 3, 0, 1'b0, 1'b0, -1);
    // Watchdog expiry, and done landing exactly on the last allowed cycle
    run_op(3'b010, 3'b000, -1, 1'b1, 5'h08, $urandom, -1, 2, 1'b0, 1'b0, -1);
    run_op(3'b011, 3'b000, TB_TIMEOUT - 1, 1'b1, 5'h02, $urandom, -1, 0, 1'b0, 1'b0, -1);
    // fflags clear coincident with an update
    run_op(3'b000, 3'b000, 1, 1'b1, 5'h03, $urandom, -1, 0, 1'b0, 1'b1, -1);
    run_op(3'b000, 3'b000, 3, 1'b1, 5'h10, $urandom, -1, 0, 1'b0, 1'b1, -1);
    // Flush cancels a held result even with out_ready
    run_op(3'b100, 3'b000, 2, 1'b1, 5'h01, $urandom, -1, 1, 1'b1, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) dl = -1;
      else dl = int'($urandom_range(0, TB_TIMEOUT - 1));
      if ($urandom_range(0, 6) == 0) fa = int'($urandom_range(0, TB_TIMEOUT - 1));
      else fa = -1;
      run_op(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), dl, 1'($urandom),
             5'($urandom), $urandom, fa, int'($urandom_range(0, 3)),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0), -1);
    end

    // Reset in the middle of a long op
    run_op(3'b001, 3'b000, -1, 1'b1, 5'h01, $urandom, -1, 0, 1'b0, 1'b0, 5);
    repeat (2) @(negedge clk);
    check("final_idle", 80'({out_valid, fpu_enable, in_ready}), 80'(3'b001));
    check("queue_drained", 80'(exp_q.size()), 80'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
